// File: rtl/max_issue_scheduler.sv
// Issues {src1,src2,dst} max instructions round-robin to external max units and writes results back.
// Start pulses one cycle after the handshake; inst_ready stalls on RAW/WAW hazards or when no unit is free.
module max_issue_scheduler #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W    = 32,
  parameter int NREG      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          inst_valid_i,
  output logic                          inst_ready_o,
  input  logic [11:0]                   inst_i,
  input  logic                          wr_en_i,
  input  logic [3:0]                    wr_addr_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic [3:0]                    rd_addr_i,
  output logic [DATA_W-1:0]             rd_data_o,
  output logic [NUM_UNITS-1:0]          unit_start_o,
  output logic [NUM_UNITS*DATA_W-1:0]   unit_a_o,
  output logic [NUM_UNITS*DATA_W-1:0]   unit_b_o,
  input  logic [NUM_UNITS-1:0]          unit_done_i,
  input  logic [NUM_UNITS*DATA_W-1:0]   unit_result_i,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [DATA_W-1:0]    regs_q [NREG];
  logic [DATA_W-1:0]    regs_d [NREG];
  logic [NREG-1:0]      pending_q, pending_d;
  logic [NUM_UNITS-1:0] busy_q, busy_d;
  logic [3:0]           tag_q [NUM_UNITS];
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [NUM_UNITS-1:0] start_q;
  logic [DATA_W-1:0]    a_q [NUM_UNITS];
  logic [DATA_W-1:0]    b_q [NUM_UNITS];
  logic                 err_q, err_d;

  logic [3:0]           src1, src2, dst;
  logic                 issue;
  logic [PTR_W-1:0]     sel, sel_next, cand_p;
  logic                 found;
  int                   cand;

  assign src1 = inst_i[11:8];
  assign src2 = inst_i[7:4];
  assign dst  = inst_i[3:0];

  assign inst_ready_o = rst_n_i && !(&busy_q) && !pending_q[src1]
                        && !pending_q[src2] && !pending_q[dst];
  assign issue = inst_valid_i && inst_ready_o;

  // First free unit at or after rr_ptr, wrapping; NUM_UNITS need not be a power of two.
  always_comb begin
    sel    = '0;
    found  = 1'b0;
    cand   = 0;
    cand_p = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_UNITS) cand = cand - NUM_UNITS;
      cand_p = PTR_W'(cand);
      if (!found && !busy_q[cand_p]) begin
        found = 1'b1;
        sel   = cand_p;
      end
    end
  end

  assign sel_next = (sel == PTR_W'(NUM_UNITS - 1)) ? '0 : sel + 1'b1;

  // Writebacks are applied after the preload so they win on an address clash.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    err_d     = err_q;
    if (wr_en_i) regs_d[wr_addr_i] = wr_data_i;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (unit_done_i[i]) begin
        if (busy_q[i]) begin
          regs_d[tag_q[i]]    = unit_result_i[i*DATA_W +: DATA_W];
          pending_d[tag_q[i]] = 1'b0;
          busy_d[i]           = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
    end
    if (issue) begin
      pending_d[dst] = 1'b1;
      busy_d[sel]    = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
        a_q[u]   <= '0;
        b_q[u]   <= '0;
        tag_q[u] <= '0;
      end
      pending_q <= '0;
      busy_q    <= '0;
      rr_ptr_q  <= '0;
      start_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      start_q   <= issue ? (NUM_UNITS'(1) << sel) : '0;
      if (issue) begin
        a_q[sel]   <= regs_q[src1];
        b_q[sel]   <= regs_q[src2];
        tag_q[sel] <= dst;
        rr_ptr_q   <= sel_next;
      end
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_flat
    assign unit_a_o[g*DATA_W +: DATA_W] = a_q[g];
    assign unit_b_o[g*DATA_W +: DATA_W] = b_q[g];
  end

  assign unit_start_o = start_q;
  assign rd_data_o    = regs_q[rd_addr_i];
  assign busy_o       = |busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_max_issue_scheduler.sv
// Directed, table-driven bench for max_issue_scheduler (NUM_UNITS=4, DATA_W=32).
module tb_max_issue_scheduler;
  localparam int NU = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            inst_valid, inst_ready;
  logic [11:0]     inst;
  logic            wr_en;
  logic [3:0]      wr_addr, rd_addr;
  logic [DW-1:0]   wr_data, rd_data;
  logic [NU-1:0]   unit_start, unit_done;
  logic [NU*DW-1:0] unit_a, unit_b, unit_result;
  logic            busy, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  max_issue_scheduler #(.NUM_UNITS(NU), .DATA_W(DW), .NREG(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .inst_valid_i(inst_valid), .inst_ready_o(inst_ready), .inst_i(inst),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .unit_start_o(unit_start), .unit_a_o(unit_a), .unit_b_o(unit_b),
    .unit_done_i(unit_done), .unit_result_i(unit_result),
    .busy_o(busy), .err_o(err)
  );

  typedef struct {
    bit          rst;
    bit          vld;
    logic [11:0] inst;
    bit          wen;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  done;
    logic [31:0] res;
    logic [3:0]  ra;
    bit          e_ready;
    logic [3:0]  e_start;
    logic [31:0] e_rd;
    bit          e_busy;
    bit          e_err;
    int          cu;
    logic [31:0] e_a;
    logic [31:0] e_b;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit vld, input logic [11:0] in,
                     input bit wen, input logic [3:0] wa, input logic [31:0] wd,
                     input logic [3:0] done, input logic [31:0] res, input logic [3:0] ra,
                     input bit er, input logic [3:0] es, input logic [31:0] erd,
                     input bit eb, input bit ee, input int cu,
                     input logic [31:0] ea, input logic [31:0] ebv);
    vec_t v;
    v.rst = rst; v.vld = vld; v.inst = in; v.wen = wen; v.wa = wa; v.wd = wd;
    v.done = done; v.res = res; v.ra = ra; v.e_ready = er; v.e_start = es;
    v.e_rd = erd; v.e_busy = eb; v.e_err = ee; v.cu = cu; v.e_a = ea; v.e_b = ebv;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit rn, input bit vld, input logic [11:0] in, input bit wen,
                     input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] done,
                     input logic [NU*DW-1:0] res, input logic [3:0] ra);
    @(negedge clk);
    rst_n = rn; inst_valid = vld; inst = in; wr_en = wen; wr_addr = wa; wr_data = wd;
    unit_done = done; unit_result = res; rd_addr = ra;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic [NU*DW-1:0] r;

    // Test 1: preload, single issue, writeback after 3-cycle unit latency
    add(0,0,12'h000,1,1,5,   0,0,0,  1,4'b0000,0,0,0, -1,0,0);
    add(0,0,12'h000,1,2,9,   0,0,1,  1,4'b0000,5,0,0, -1,0,0);
    add(0,1,12'h123,0,0,0,   0,0,2,  1,4'b0000,9,0,0, -1,0,0);
    add(0,0,12'h123,0,0,0,   0,0,3,  0,4'b0001,0,1,0,  0,5,9);
    add(0,0,12'h123,0,0,0,   0,0,3,  0,4'b0000,0,1,0, -1,0,0);
    add(0,0,12'h123,0,0,0,   0,0,3,  0,4'b0000,0,1,0, -1,0,0);
    add(0,0,12'h123,0,0,0,   4'b0001,9,3, 0,4'b0000,0,1,0, -1,0,0);
    // Test 2: RAW stall on r3 until the cycle after its writeback
    add(0,1,12'h123,0,0,0,   0,0,3,  1,4'b0000,9,0,0, -1,0,0);
    add(0,1,12'h345,0,0,0,   0,0,3,  0,4'b0010,9,1,0,  1,5,9);
    add(0,1,12'h345,0,0,0,   0,0,3,  0,4'b0000,9,1,0, -1,0,0);
    add(0,1,12'h345,0,0,0,   4'b0010,9,3, 0,4'b0000,9,1,0, -1,0,0);
    add(0,1,12'h345,0,0,0,   0,0,3,  1,4'b0000,9,0,0, -1,0,0);
    add(0,0,12'h345,0,0,0,   0,0,5,  0,4'b0100,0,1,0,  2,9,0);
    add(0,0,12'h345,0,0,0,   4'b0100,9,5, 0,4'b0000,0,1,0, -1,0,0);
    add(0,0,12'h345,0,0,0,   0,0,5,  1,4'b0000,9,0,0, -1,0,0);
    // Test 3: reset, four independent issues fill all units, fifth waits for a free unit
    add(1,1,12'h120,0,0,0,   0,0,5,  0,4'b0000,0,0,0, -1,0,0);
    add(0,0,12'h120,1,1,32'h11, 0,0,0, 1,4'b0000,0,0,0, -1,0,0);
    add(0,1,12'h120,1,4,32'h44, 0,0,1, 1,4'b0000,32'h11,0,0, -1,0,0);
    add(0,1,12'h341,0,0,0,   0,0,4,  1,4'b0001,32'h44,1,0, 0,32'h11,0);
    add(0,1,12'h562,0,0,0,   0,0,0,  1,4'b0010,0,1,0,  1,0,32'h44);
    add(0,1,12'h783,0,0,0,   0,0,0,  1,4'b0100,0,1,0,  2,0,0);
    add(0,1,12'h9A4,0,0,0,   0,0,0,  0,4'b1000,0,1,0,  3,0,0);
    add(0,1,12'h9A4,0,0,0,   4'b0001,32'h55,0, 0,4'b0000,0,1,0, -1,0,0);
    add(0,1,12'h9A4,0,0,0,   0,0,0,  1,4'b0000,32'h55,1,0, -1,0,0);
    add(0,0,12'h9A4,0,0,0,   0,0,0,  0,4'b0001,32'h55,1,0, 0,0,0);
    add(0,0,12'h9A4,0,0,0,   4'b1110,32'h77,1, 0,4'b0000,32'h11,1,0, -1,0,0);
    add(0,0,12'h9A4,0,0,0,   4'b0001,32'h66,1, 0,4'b0000,32'h77,1,0, -1,0,0);
    add(0,0,12'h9A4,0,0,0,   0,0,4,  1,4'b0000,32'h66,0,0, -1,0,0);

    rst_n = 1'b0; inst_valid = 1'b0; inst = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; unit_done = '0; unit_result = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset ready", inst_ready, 0);
    chk("reset start", unit_start, 0);
    chk("reset unit_a", unit_a, 0);
    chk("reset unit_b", unit_b, 0);
    chk("reset busy", busy, 0);
    chk("reset err", err, 0);
    chk("reset rd", rd_data, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n = !tbl[i].rst; inst_valid = tbl[i].vld; inst = tbl[i].inst;
      wr_en = tbl[i].wen; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      unit_done = tbl[i].done; unit_result = {NU{tbl[i].res}}; rd_addr = tbl[i].ra;
      #1;
      chk($sformatf("v%0d ready", i), inst_ready, tbl[i].e_ready);
      chk($sformatf("v%0d start", i), unit_start, tbl[i].e_start);
      chk($sformatf("v%0d rd", i), rd_data, tbl[i].e_rd);
      chk($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d err", i), err, tbl[i].e_err);
      if (tbl[i].cu >= 0) begin
        chk($sformatf("v%0d unit_a[%0d]", i, tbl[i].cu), unit_a[tbl[i].cu*DW +: DW], tbl[i].e_a);
        chk($sformatf("v%0d unit_b[%0d]", i, tbl[i].cu), unit_b[tbl[i].cu*DW +: DW], tbl[i].e_b);
      end
    end

    // Tests 4/5: simultaneous writebacks, writeback beats preload, done on free unit
    cyc(0,0,12'h000,0,0,0,0,'0,0);
    chk("B reset ready", inst_ready, 0);
    cyc(1,0,12'h000,1,1,32'h10,0,'0,0);
    cyc(1,0,12'h000,1,2,32'h20,0,'0,0);
    cyc(1,1,12'h120,0,0,0,0,'0,0);
    chk("B issue0 ready", inst_ready, 1);
    cyc(1,1,12'h125,0,0,0,0,'0,0);
    chk("B start u0", unit_start, 4'b0001);
    chk("B issue1 ready", inst_ready, 1);
    cyc(1,1,12'h126,0,0,0,0,'0,0);
    chk("B start u1", unit_start, 4'b0010);
    cyc(1,0,12'h126,0,0,0,0,'0,0);
    chk("B start u2", unit_start, 4'b0100);
    chk("B unit_a[2]", unit_a[2*DW +: DW], 32'h10);
    chk("B unit_b[2]", unit_b[2*DW +: DW], 32'h20);
    chk("B waw stall", inst_ready, 0);
    r = '0; r[1*DW +: DW] = 32'hAA; r[2*DW +: DW] = 32'hBB;
    cyc(1,0,12'h000,1,6,32'h123,4'b0110,r,6);
    chk("B r6 before wb", rd_data, 0);
    r = '0; r[3*DW +: DW] = 32'hDEAD;
    cyc(1,0,12'h000,0,0,0,4'b1000,r,6);
    chk("B wb beats wr r6", rd_data, 32'hBB);
    chk("B err before stray", err, 0);
    chk("B busy u0", busy, 1);
    cyc(1,1,12'h347,0,0,0,0,'0,5);
    chk("B r5 wb", rd_data, 32'hAA);
    chk("B err set", err, 1);
    chk("B ready after wb", inst_ready, 1);
    cyc(1,1,12'h348,0,0,0,0,'0,0);
    chk("B start u3", unit_start, 4'b1000);
    chk("B r0 untouched", rd_data, 0);
    cyc(1,1,12'h349,0,0,0,0,'0,0);
    chk("B wrap skips u0 to u1", unit_start, 4'b0010);
    cyc(1,0,12'h349,0,0,0,0,'0,0);
    chk("B reissue u2", unit_start, 4'b0100);
    chk("B ready pending9", inst_ready, 0);
    chk("B err sticky", err, 1);

    // Test 6: reset with units in flight, then a stale done
    cyc(0,1,12'h000,0,0,0,0,'0,5);
    chk("C ready in reset", inst_ready, 0);
    chk("C busy in reset", busy, 0);
    chk("C err in reset", err, 0);
    cyc(0,0,12'h000,0,0,0,0,'0,5);
    chk("C r5 cleared", rd_data, 0);
    cyc(1,0,12'h000,0,0,0,0,'0,5);
    chk("C ready after release", inst_ready, 1);
    chk("C busy after release", busy, 0);
    r = '0; r[1*DW +: DW] = 32'hEE;
    cyc(1,0,12'h000,0,0,0,4'b0010,r,0);
    chk("C err before stale", err, 0);
    cyc(1,0,12'h000,0,0,0,0,'0,0);
    chk("C err after stale", err, 1);
    chk("C r0 unchanged", rd_data, 0);
    cyc(1,0,12'h000,0,0,0,0,'0,5);
    chk("C r5 unchanged", rd_data, 0);
    chk("C busy idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
